// File: rtl/fp_pkg.sv
// Shared float32 constants and the accumulator sequencer state encoding.
package fp_pkg;

    localparam int              FP_W    = 32;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accum_state_t;

endpackage : fp_pkg

// File: rtl/flp_adder.sv
// Shared combinational float32 adder: round-to-nearest on the guard bits,
// subnormal inputs and results flush to zero, Inf/NaN operands pass through.
module flp_adder
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] num1,
    input  logic [FP_W-1:0] num2,
    output logic [FP_W-1:0] sum
);

    logic              w_a_big;
    logic [FP_W-1:0]   w_big;
    logic [FP_W-1:0]   w_small;
    logic [7:0]        w_shift;
    logic [26:0]       w_m_big;
    logic [26:0]       w_m_small;
    logic [27:0]       w_raw;
    logic [4:0]        w_lz;
    logic              w_found;
    logic [26:0]       w_norm;
    logic signed [9:0] w_exp;
    logic              w_round_up;
    logic [24:0]       w_mant;
    logic [22:0]       w_frac;
    logic [FP_W-1:0]   w_main;

    // Ordering by magnitude keeps the subtraction non-negative, so the result sign is the big operand's.
    assign w_a_big = (num1[30:0] >= num2[30:0]);
    assign w_big   = w_a_big ? num1 : num2;
    assign w_small = w_a_big ? num2 : num1;

    always_comb begin
        // NOTE: every variable gets a value on every path through this block; a path
        // that leaves one unassigned would make synthesis infer a latch to hold it.
        w_shift   = w_big[30:23] - w_small[30:23];
        w_m_big   = {1'b1, w_big[22:0], 3'b000};
        w_m_small = (w_shift > 8'd26) ? '0 : ({1'b1, w_small[22:0], 3'b000} >> w_shift);

        if (w_big[31] == w_small[31]) begin
            w_raw = {1'b0, w_m_big} + {1'b0, w_m_small};
        end else begin
            w_raw = {1'b0, w_m_big} - {1'b0, w_m_small};
        end

        w_lz    = '0;
        w_found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!w_found && w_raw[i]) begin
                w_lz    = 5'(26 - i);
                w_found = 1'b1;
            end
        end

        w_exp = $signed({2'b00, w_big[30:23]});
        if (w_raw[27]) begin
            w_norm = w_raw[27:1];
            w_exp  = w_exp + 10'sd1;
        end else begin
            w_norm = w_raw[26:0] << w_lz;
            w_exp  = w_exp - $signed({5'b00000, w_lz});
        end

        w_round_up = w_norm[2] & (w_norm[3] | (|w_norm[1:0]));
        w_mant     = {1'b0, w_norm[26:3]} + {24'b0, w_round_up};
        if (w_mant[24]) begin
            w_exp  = w_exp + 10'sd1;
            w_frac = w_mant[23:1];
        end else begin
            w_frac = w_mant[22:0];
        end

        if (w_raw == '0 || w_exp <= 10'sd0) begin
            w_main = FP_ZERO;
        end else if (w_exp >= 10'sd255) begin
            w_main = {w_big[31], 8'hFF, 23'b0};
        end else begin
            w_main = {w_big[31], w_exp[7:0], w_frac};
        end

        if (num1[30:23] == 8'hFF) begin
            sum = num1;
        end else if (num2[30:23] == 8'hFF) begin
            sum = num2;
        end else if (num2[30:23] == 8'h00) begin
            sum = (num1[30:23] == 8'h00) ? {num1[31] & num2[31], 31'b0} : num1;
        end else if (num1[30:23] == 8'h00) begin
            sum = num2;
        end else begin
            sum = w_main;
        end
    end

endmodule : flp_adder

// File: rtl/fp_accum_seq.sv
// Reduces LEN float32 operands into one running sum through an external shared
// adder, one operand per clock, starting from a bias value.
module fp_accum_seq
    import fp_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [FP_W-1:0]  bias,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [FP_W-1:0]  in_data,
    output logic             in_ready,
    output logic [FP_W-1:0]  add_a,
    output logic [FP_W-1:0]  add_b,
    input  logic [FP_W-1:0]  add_sum,
    output logic             res_valid,
    output logic [FP_W-1:0]  res_data,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);

    accum_state_t     r_state;
    accum_state_t     w_state_nxt;
    logic [FP_W-1:0]  r_acc;
    logic [FP_W-1:0]  w_acc_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             w_xfer;

    assign in_ready  = (r_state == ACCUM) && !flush;
    assign w_xfer    = in_valid && in_ready;
    assign add_a     = r_acc;
    assign add_b     = in_data;
    assign res_valid = (r_state == DONE);
    assign res_data  = (r_state == DONE) ? r_acc : FP_ZERO;
    assign busy      = (r_state != IDLE);
    assign remaining = r_remaining;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_rem_nxt   = r_remaining;

        // Flush outranks every transition, including start while idle.
        if (flush) begin
            if (r_state != IDLE) begin
                w_state_nxt = IDLE;
                w_rem_nxt   = '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_acc_nxt   = bias;
                        w_rem_nxt   = len;
                        w_state_nxt = (len != '0) ? ACCUM : DONE;
                    end
                end
                ACCUM: begin
                    if (w_xfer && r_remaining != '0) begin
                        w_acc_nxt = add_sum;
                        w_rem_nxt = r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            w_state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= FP_ZERO;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_remaining <= w_rem_nxt;
        end
    end

endmodule : fp_accum_seq

// File: tb/tb_fp_accum_seq.sv
// Self-checking bench for fp_accum_seq driving a real flp_adder beside it.
module tb_fp_accum_seq;
    import fp_pkg::*;

    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic [31:0]      bias;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_sum;
    logic             res_valid;
    logic [31:0]      res_data;
    logic             res_ready;
    logic             busy;
    logic [CNT_W-1:0] remaining;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [31:0]      bias;
        logic [CNT_W-1:0] len;
        logic [3:0][31:0] ops;
        logic [31:0]      res;
    } vec_t;

    vec_t vt[6];

    fp_accum_seq #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .bias     (bias),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sum  (add_sum),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_ready(res_ready),
        .busy     (busy),
        .remaining(remaining)
    );

    flp_adder u_add (
        .num1(add_a),
        .num2(add_b),
        .sum (add_sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] b, input int l, input logic [31:0] o0,
                                input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] r);
        vec_t v;
        v.bias   = b;
        v.len    = CNT_W'(l);
        v.ops[0] = o0;
        v.ops[1] = o1;
        v.ops[2] = o2;
        v.ops[3] = 32'h0;
        v.res    = r;
        return v;
    endfunction

    task automatic start_red(input logic [31:0] b, input int l, input logic [31:0] r,
                             input bit push, output int s);
        @(negedge clk);
        start = 1'b1;
        bias  = b;
        len   = CNT_W'(l);
        s     = cyc;
        if (push) exp_q.push_back(r);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_op(input logic [31:0] d);
        int t = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_res();
        int t = 0;
        while (!res_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("res_valid_wait", 32'(res_valid), 32'd1);
    endtask

    task automatic get_result(input string name, input int s, input int lat);
        logic [31:0] exp;
        wait_res();
        if (lat >= 0) check({name, "_latency"}, 32'(cyc - s), 32'(lat));
        check({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({name, "_res_data"}, res_data, exp);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({name, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int s;
        logic [31:0] held;

        rst_n = 1'b0; start = 1'b0; len = '0; bias = '0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; res_ready = 1'b0;

        vt[0] = mk(FP_ONE,       3, FP_ONE,       FP_ONE,       FP_ONE, 32'h4080_0000);
        vt[1] = mk(FP_ZERO,      2, FP_ONE,       32'h4000_0000, 32'h0, 32'h4040_0000);
        vt[2] = mk(32'h4040_0000, 0, 32'h0,       32'h0,        32'h0, 32'h4040_0000);
        vt[3] = mk(FP_ZERO,      1, 32'h40A0_0000, 32'h0,       32'h0, 32'h40A0_0000);
        vt[4] = mk(32'h4000_0000, 2, 32'hBF80_0000, 32'hBF80_0000, 32'h0, FP_ZERO);
        vt[5] = mk(32'h3F00_0000, 2, 32'h3F00_0000, 32'h3E80_0000, 32'h0, 32'h3FA0_0000);

        repeat (2) @(negedge clk);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_add_a",     add_a,          FP_ZERO);
        check("rst_remaining", 32'(remaining), 32'd0);
        rst_n = 1'b1;

        // Table: back-to-back operands, latency len+1 clocks from start.
        for (int i = 0; i < 6; i++) begin
            start_red(vt[i].bias, int'(vt[i].len), vt[i].res, 1'b1, s);
            for (int k = 0; k < int'(vt[i].len); k++) send_op(vt[i].ops[k]);
            get_result($sformatf("vec%0d", i), s, int'(vt[i].len) + 1);
        end

        // Bubbles on in_valid, ignored start mid-ACCUM, result held under back-pressure.
        start_red(FP_ZERO, 3, 32'h4040_0000, 1'b1, s);
        send_op(FP_ONE);
        start = 1'b1;
        len   = CNT_W'(7);
        @(negedge clk);
        start = 1'b0;
        check("gap_remaining", 32'(remaining), 32'd2);
        check("gap_acc",       add_a,          FP_ONE);
        @(negedge clk);
        check("gap_acc2",      add_a,          FP_ONE);
        send_op(FP_ONE);
        @(negedge clk);
        check("gap_remaining2", 32'(remaining), 32'd1);
        send_op(FP_ONE);
        wait_res();
        held = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data",  res_data,       held);
        end
        get_result("gaps", s, -1);

        // start together with the DONE handshake is ignored.
        start_red(32'h4040_0000, 0, 32'h4040_0000, 1'b0, s);
        wait_res();
        check("hs_res_data", res_data, 32'h4040_0000);
        res_ready = 1'b1;
        start     = 1'b1;
        len       = CNT_W'(5);
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        check("hs_busy",      32'(busy),      32'd0);
        check("hs_remaining", 32'(remaining), 32'd0);
        @(negedge clk);
        check("hs_still_idle", 32'(busy), 32'd0);

        // Flush after 1 of 4 operands.
        start_red(FP_ZERO, 4, FP_ZERO, 1'b0, s);
        send_op(FP_ONE);
        in_data  = FP_ONE;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_busy",      32'(busy),      32'd0);
        check("flush_remaining", 32'(remaining), 32'd0);
        check("flush_acc_kept",  add_a,          FP_ONE);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("flush_no_res", 32'(res_valid), 32'd0);
        end
        start_red(vt[1].bias, int'(vt[1].len), vt[1].res, 1'b1, s);
        for (int k = 0; k < int'(vt[1].len); k++) send_op(vt[1].ops[k]);
        get_result("after_flush", s, 3);

        // Asynchronous reset mid-ACCUM.
        start_red(FP_ZERO, 3, FP_ZERO, 1'b0, s);
        send_op(FP_ONE);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  32'(in_ready),  32'd0);
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_res_valid", 32'(res_valid), 32'd0);
        check("arst_res_data",  res_data,       FP_ZERO);
        check("arst_add_a",     add_a,          FP_ZERO);
        check("arst_remaining", 32'(remaining), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_red(vt[0].bias, int'(vt[0].len), vt[0].res, 1'b1, s);
        for (int k = 0; k < int'(vt[0].len); k++) send_op(vt[0].ops[k]);
        get_result("after_rst", s, 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fp_accum_seq
